// File: rtl/mem_access_unit.sv
// Load/store sequencer between the CPU datapath and a word-wide RAM without
// byte enables. Sub-word loads are extracted and extended. Sub-word stores
// become read-modify-write sequences. Misaligned or illegal requests are
// answered with err and never touch the RAM.
module mem_access_unit #(
    parameter int RAM_AW = 10,
    parameter int DATA_W = 32    // lane logic assumes 32
) (
    input  logic              clk,
    input  logic              clr_n,
    input  logic              req,
    input  logic              we,
    input  logic [2:0]        op,
    input  logic [RAM_AW+1:0] byte_addr,
    input  logic [DATA_W-1:0] wdata,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [DATA_W-1:0] rdata,
    output logic              ram_sel,
    output logic              ram_ld,
    output logic              ram_str,
    output logic [RAM_AW-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_din,
    input  logic [DATA_W-1:0] ram_dout
);

    localparam logic [2:0] OP_B  = 3'b000;
    localparam logic [2:0] OP_H  = 3'b001;
    localparam logic [2:0] OP_W  = 3'b010;
    localparam logic [2:0] OP_BU = 3'b100;
    localparam logic [2:0] OP_HU = 3'b101;

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD,
        S_CAP,
        S_WR,
        S_RESP
    } state_t;

    state_t state, state_nxt;

    logic        accept;
    logic        req_err;
    logic        we_q;
    logic [2:0]  op_q;
    logic [1:0]  lo_q;
    logic [15:0] wdata_q;     // only byte/half payload is needed after accept
    logic        err_q;
    logic [DATA_W-1:0] merged;
    logic [DATA_W-1:0] load_val;
    logic [7:0]  byte_lane;
    logic [15:0] half_lane;

    // Classify the incoming request: illegal op, store of an unsigned op, or misalignment.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        req_err = 1'b0;
        case (op)
            OP_B:    req_err = 1'b0;
            OP_H:    req_err = byte_addr[0];
            OP_W:    req_err = |byte_addr[1:0];
            OP_BU:   req_err = we;
            OP_HU:   req_err = we | byte_addr[0];
            default: req_err = 1'b1;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
        if (!clr_n) state <= S_IDLE;
        else        state <= state_nxt;
    end

    // Next-state and RAM strobe decode.
    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        busy      = (state != S_IDLE);
        done      = (state == S_RESP);
        err       = (state == S_RESP) & err_q;
        ram_sel   = 1'b0;
        ram_ld    = 1'b0;
        ram_str   = 1'b0;
        case (state)
            S_IDLE: begin
                if (req) begin
                    accept = 1'b1;
                    if (req_err)               state_nxt = S_RESP;
                    else if (we && op == OP_W) state_nxt = S_WR;
                    else                       state_nxt = S_RD;
                end
            end
            S_RD: begin
                ram_sel   = 1'b1;
                ram_ld    = 1'b1;
                state_nxt = S_CAP;
            end
            S_CAP: begin
                // Read strobe held so the RAM output stays valid for the capture edge.
                ram_sel   = 1'b1;
                ram_ld    = 1'b1;
                state_nxt = we_q ? S_WR : S_RESP;
            end
            S_WR: begin
                ram_sel   = 1'b1;
                ram_str   = 1'b1;
                state_nxt = S_RESP;
            end
            S_RESP:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Lane extraction for loads and lane replacement for read-modify-write stores.
    always_comb begin
        byte_lane = ram_dout[{lo_q, 3'b000} +: 8];
        half_lane = ram_dout[{lo_q[1], 4'b0000} +: 16];
        merged    = ram_dout;
        if (op_q[0]) merged[{lo_q[1], 4'b0000} +: 16] = wdata_q;
        else         merged[{lo_q, 3'b000} +: 8]      = wdata_q[7:0];
        case (op_q)
            OP_B:    load_val = {{24{byte_lane[7]}}, byte_lane};
            OP_H:    load_val = {{16{half_lane[15]}}, half_lane};
            OP_BU:   load_val = {24'h0, byte_lane};
            OP_HU:   load_val = {16'h0, half_lane};
            default: load_val = ram_dout;
        endcase
    end

    // Request latching, load result capture and store-word assembly.
    always_ff @(posedge clk) begin
        if (!clr_n) begin
            we_q     <= 1'b0;
            op_q     <= 3'b000;
            lo_q     <= 2'b00;
            wdata_q  <= 16'h0;
            err_q    <= 1'b0;
            rdata    <= '0;
            ram_addr <= '0;
            ram_din  <= '0;
        end else begin
            if (accept) begin
                we_q     <= we;
                op_q     <= op;
                lo_q     <= byte_addr[1:0];
                wdata_q  <= wdata[15:0];
                err_q    <= req_err;
                ram_addr <= byte_addr[RAM_AW+1:2];
                if (we && op == OP_W && !req_err) ram_din <= wdata;
            end
            if (state == S_CAP) begin
                if (we_q) ram_din <= merged;
                else      rdata   <= load_val;
            end
        end
    end

endmodule
